// File: rtl/tx_serializer.sv
// tx_serializer: pulls bytes from the TX FIFO, 8b10b-encodes them with a
// running-disparity register, inserts a K28.5 comma in slot 0 of every packet
// (and as filler when the FIFO runs dry) and shifts each symbol out LSB first.
// Optional build macro TX_SERIALIZER_STATS_EN adds saturating data/filler
// symbol counters on the stat_data / stat_fill ports.
module tx_serializer #(
  parameter int NUM_BYTES_PER_PACKET = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  output logic        fifo_ren,
  input  logic [7:0]  fifo_dout,
  output logic        strobout,
  output logic        busy
`ifdef TX_SERIALIZER_STATS_EN
  ,
  output logic [15:0] stat_data,
  output logic [15:0] stat_fill
`endif
);
  localparam int SW = (NUM_BYTES_PER_PACKET > 1) ? $clog2(NUM_BYTES_PER_PACKET) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_BYTES_PER_PACKET - 1);
  localparam logic [9:0] K28_5_NEG = 10'h0FA;
  localparam logic [9:0] K28_5_POS = 10'h305;

  logic [9:0]    sym_sr;
  logic [3:0]    bit_cnt;
  logic [SW-1:0] slot_cnt;
  logic          rd;
  logic          ren_p1;
  logic [7:0]    byte_r;
  logic          have_byte;

  logic          next_is_data;
  logic [9:0]    data_sym;
  logic          data_rd;

  // 5b/6b table, RD- column, abcdei order (a in bit 5)
  function automatic logic [5:0] enc6_neg(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;  5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;  5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;  5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;  5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;  default: r = 6'b101011;
    endcase
    return r;
  endfunction

  // 3b/4b table, RD- column, fghj order; y=7 here is the primary P7 code
  function automatic logic [3:0] enc4_neg(input logic [2:0] y);
    logic [3:0] r;
    case (y)
      3'd0: r = 4'b1011;  3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;  3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;  3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;  default: r = 4'b1110;
    endcase
    return r;
  endfunction

`ifdef TX_SERIALIZER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  assign next_is_data = (slot_cnt != LAST_SLOT);
  assign fifo_ren     = (bit_cnt == 4'd7) && next_is_data && !fifo_empty;
  assign strobout     = sym_sr[0];

  // Dx.y encode of the held byte against the current running disparity
  always_comb begin
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] t6;
    logic [3:0] t4;
    logic       flip6, flip4, alt6, alt4, rd_mid, use_a7;
    x      = byte_r[4:0];
    y      = byte_r[7:5];
    t6     = enc6_neg(x);
    flip6  = ($countones(t6) != 3);
    alt6   = flip6 || (x == 5'd7);
    rd_mid = rd ^ flip6;
    use_a7 = (y == 3'd7) &&
             ((!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    t4     = use_a7 ? 4'b0111 : enc4_neg(y);
    flip4  = ($countones(t4) != 2);
    alt4   = flip4 || (y == 3'd3);
    data_sym = {(rd && alt6) ? ~t6 : t6, (rd_mid && alt4) ? ~t4 : t4};
    data_rd  = rd_mid ^ flip4;
  end

  // Bit/slot counters, byte capture, symbol load and serial shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_sr    <= K28_5_NEG;
      bit_cnt   <= 4'd0;
      slot_cnt  <= '0;
      rd        <= 1'b1;
      ren_p1    <= 1'b0;
      byte_r    <= 8'd0;
      have_byte <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ren_p1 <= fifo_ren;
      if (bit_cnt == 4'd9) begin
        bit_cnt   <= 4'd0;
        slot_cnt  <= slot_cnt + SW'(1);
        have_byte <= 1'b0;
        if (next_is_data && have_byte) begin
          sym_sr <= data_sym;
          rd     <= data_rd;
          busy   <= 1'b1;
        end else begin
          // K28.5 has an unbalanced 6b half and a balanced 4b half: it always flips RD
          sym_sr <= rd ? K28_5_POS : K28_5_NEG;
          rd     <= ~rd;
          busy   <= 1'b0;
        end
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        sym_sr  <= {1'b0, sym_sr[9:1]};
        if (bit_cnt == 4'd8 && ren_p1) begin
          byte_r    <= fifo_dout;
          have_byte <= 1'b1;
        end
      end
    end
  end

`ifdef TX_SERIALIZER_STATS_EN
  // Saturating counts of data-symbol loads and filler-comma loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_data <= 16'd0;
      stat_fill <= 16'd0;
    end else if (bit_cnt == 4'd9 && next_is_data) begin
      if (have_byte) stat_data <= sat_inc(stat_data);
      else           stat_fill <= sat_inc(stat_fill);
    end
  end
`endif

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer with a small FIFO model and hand-computed
// 8b10b symbols. Stats ports are checked when TX_SERIALIZER_STATS_EN is defined.
module tb_tx_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic       fifo_ren;
  logic [7:0] fifo_dout = 8'd0;
  logic       strobout;
  logic       busy;
`ifdef TX_SERIALIZER_STATS_EN
  logic [15:0] stat_data;
  logic [15:0] stat_fill;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int ren_viol = 0;

  tx_serializer #(.NUM_BYTES_PER_PACKET(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_empty(fifo_empty),
    .fifo_ren(fifo_ren),
    .fifo_dout(fifo_dout),
    .strobout(strobout),
    .busy(busy)
`ifdef TX_SERIALIZER_STATS_EN
    ,
    .stat_data(stat_data),
    .stat_fill(stat_fill)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO model: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (fifo_ren) begin
      if (fifo_empty) ren_viol <= ren_viol + 1;
      else begin
        fifo_dout <= fifo_mem[rd_ptr % 64];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Collects one symbol starting at a negedge where its bit 0 is on the line
  task automatic get_sym(output logic [9:0] s, output logic [9:0] ren, output logic b);
    b = busy;
    for (int i = 0; i < 10; i++) begin
      s[i]   = strobout;
      ren[i] = fifo_ren;
      @(negedge clk);
    end
  endtask

  logic [9:0] t2_sym  [0:10] = '{10'h0FA, 10'h18B, 10'h18B, 10'h305, 10'h237, 10'h348,
                                 10'h38C, 10'h2B9, 10'h305, 10'h1CE, 10'h305};
  logic [9:0] t2_ren  [0:10] = '{10'h080, 10'h080, 10'h000, 10'h080, 10'h080, 10'h080,
                                 10'h080, 10'h000, 10'h080, 10'h000, 10'h000};
  logic       t2_busy [0:10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [9:0] s, r;
    logic       b;

    // Reset values with an empty FIFO
    repeat (3) @(negedge clk);
    check("rst_strobout", strobout, 1'b0);
    check("rst_fifo_ren", fifo_ren, 1'b0);
    check("rst_busy", busy, 1'b0);
`ifdef TX_SERIALIZER_STATS_EN
    check("rst_stat_data", stat_data, 16'd0);
    check("rst_stat_fill", stat_fill, 16'd0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_sym(s, r, b);
      check($sformatf("t1_sym%0d", i), s, (i % 2 == 0) ? 10'h0FA : 10'h305);
      check($sformatf("t1_ren%0d", i), r, 10'h000);
      check($sformatf("t1_busy%0d", i), b, 1'b0);
    end

    // Data bytes, FIFO running dry mid-packet, refill, packet wrap
    rst_n = 1'b0;
    #1;
    check("rst2_busy", busy, 1'b0);
    wr_ptr = rd_ptr;
    push(8'h00);
    push(8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
`ifdef TX_SERIALIZER_STATS_EN
      if (i == 10) begin
        check("stat_data", stat_data, 16'd7);
        check("stat_fill", stat_fill, 16'd2);
      end
`endif
      get_sym(s, r, b);
      check($sformatf("t2_sym%0d", i), s, t2_sym[i]);
      check($sformatf("t2_ren%0d", i), r, t2_ren[i]);
      check($sformatf("t2_busy%0d", i), b, t2_busy[i]);
      if (i == 2) begin
        push(8'hF1);
        push(8'hEB);
        push(8'h67);
        push(8'h3F);
        push(8'hEE);
      end
    end

    // Reset at bit 4 of a data symbol
    rst_n = 1'b0;
    #1;
    wr_ptr = rd_ptr;
    push(8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    get_sym(s, r, b);
    check("t3_sym0", s, 10'h0FA);
    check("t3_ren0", r, 10'h080);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("t3_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t3_rst_strobout", strobout, 1'b0);
    check("t3_rst_busy", busy, 1'b0);
    check("t3_rst_ren", fifo_ren, 1'b0);
`ifdef TX_SERIALIZER_STATS_EN
    check("t3_rst_stat_data", stat_data, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    get_sym(s, r, b);
    check("t3_sym_after0", s, 10'h0FA);
    get_sym(s, r, b);
    check("t3_sym_after1", s, 10'h305);
    check("t3_busy_after1", b, 1'b0);

    check("ren_while_empty", ren_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
